// File: rtl/plic_mt.sv
// rtl/plic_mt.sv - multi-target PLIC on an Avalon-MM slave port
// Optional edge-mode gateways and the 0x21 edge-select register are built when PLIC_EDGE_SEL_EN is defined.
module plic_mt #(
    parameter int NSRC   = 16,
    parameter int NTGT   = 2,
    parameter int PRIO_W = 3
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              chipselect_i,
    input  logic              write_i,
    input  logic              read_i,
    input  logic [7:0]        address_i,
    input  logic [31:0]       writedata_i,
    output logic [31:0]       readdata_o,
    input  logic [NSRC-1:0]   irq_src_i,
    output logic [NTGT-1:0]   irq_o
);

    logic [NSRC-1:0]   r_s1;
    logic [NSRC-1:0]   r_s2;
    logic [NSRC-1:0]   r_pend;
    logic [NSRC-1:0]   r_insvc;
    logic [PRIO_W-1:0] r_prio [NSRC];
    logic [NSRC-1:0]   r_en [NTGT];
    logic [PRIO_W-1:0] r_thr [NTGT];
    logic [4:0]        r_best_id [NTGT];
    logic [NTGT-1:0]   r_irq;
    logic [31:0]       r_rdata;

    logic              w_rd;
    logic              w_wr;
    logic [31:0]       w_rdata;
    logic [NSRC-1:0]   w_claim;
    logic [NSRC-1:0]   w_cmpl;
    logic [NSRC-1:0]   w_set;
    logic [NSRC-1:0]   w_idle;
    logic [4:0]        w_arb_id [NTGT];
    logic [PRIO_W-1:0] w_arb_prio [NTGT];
    logic              w_unused_wdata;

    assign w_rd           = chipselect_i & read_i;
    assign w_wr           = chipselect_i & write_i;
    assign w_idle         = ~r_pend & ~r_insvc;
    assign w_unused_wdata = ^writedata_i;
    assign readdata_o     = r_rdata;
    assign irq_o          = r_irq;

`ifdef PLIC_EDGE_SEL_EN
    logic [NSRC-1:0] r_s3;
    logic [NSRC-1:0] r_esel;
    logic [NSRC-1:0] r_elat;

    // An edge source fires on a fresh rising edge or on an edge remembered while it was busy.
    assign w_set = (r_esel & ((r_s2 & ~r_s3) | r_elat)) | (~r_esel & r_s2);
`else
    assign w_set = r_s2;
`endif

    // Strictly-greater compare keeps the lowest ID on priority ties and excludes priority 0.
    always_comb begin
        for (int t = 0; t < NTGT; t++) begin
            w_arb_id[t]   = '0;
            w_arb_prio[t] = '0;
            for (int k = 0; k < NSRC; k++) begin
                if (r_pend[k] && r_en[t][k] && (r_prio[k] > w_arb_prio[t])) begin
                    w_arb_prio[t] = r_prio[k];
                    w_arb_id[t]   = 5'(k + 1);
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        w_claim = '0;
        w_cmpl  = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (address_i == 8'(k + 1)) w_rdata = 32'(r_prio[k]);
        end
        if (address_i == 8'h20) w_rdata = 32'(r_pend);
`ifdef PLIC_EDGE_SEL_EN
        if (address_i == 8'h21) w_rdata = 32'(r_esel);
`endif
        for (int t = 0; t < NTGT; t++) begin
            if (address_i == 8'(64 + 2 * t)) w_rdata = 32'(r_en[t]);
            if (address_i == 8'(65 + 2 * t)) w_rdata = 32'(r_thr[t]);
            if (address_i == 8'(96 + t)) begin
                w_rdata = 32'(r_best_id[t]);
                for (int k = 0; k < NSRC; k++) begin
                    if (w_rd && (r_best_id[t] == 5'(k + 1))) w_claim[k] = 1'b1;
                    if (w_wr && (writedata_i[4:0] == 5'(k + 1)) && r_insvc[k] && r_en[t][k])
                        w_cmpl[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_pend  <= '0;
            r_insvc <= '0;
            r_irq   <= '0;
            r_rdata <= '0;
            for (int k = 0; k < NSRC; k++) r_prio[k] <= '0;
            for (int t = 0; t < NTGT; t++) begin
                r_en[t]      <= '0;
                r_thr[t]     <= '0;
                r_best_id[t] <= '0;
            end
`ifdef PLIC_EDGE_SEL_EN
            r_s3   <= '0;
            r_esel <= '0;
            r_elat <= '0;
`endif
        end else begin
            r_s1    <= irq_src_i;
            r_s2    <= r_s1;
            // A claim on the same edge wins over a gateway set.
            r_pend  <= (r_pend | (w_set & w_idle)) & ~w_claim;
            r_insvc <= (r_insvc | w_claim) & ~w_cmpl;
`ifdef PLIC_EDGE_SEL_EN
            r_s3   <= r_s2;
            r_elat <= r_esel & ~w_idle & (r_elat | (r_s2 & ~r_s3));
`endif
            if (w_rd) r_rdata <= w_rdata;
            for (int t = 0; t < NTGT; t++) begin
                r_best_id[t] <= w_arb_id[t];
                r_irq[t]     <= (w_arb_prio[t] > r_thr[t]);
            end
            if (w_wr) begin
                for (int k = 0; k < NSRC; k++) begin
                    if (address_i == 8'(k + 1)) r_prio[k] <= writedata_i[PRIO_W-1:0];
                end
`ifdef PLIC_EDGE_SEL_EN
                if (address_i == 8'h21) r_esel <= writedata_i[NSRC-1:0];
`endif
                for (int t = 0; t < NTGT; t++) begin
                    if (address_i == 8'(64 + 2 * t)) r_en[t]  <= writedata_i[NSRC-1:0];
                    if (address_i == 8'(65 + 2 * t)) r_thr[t] <= writedata_i[PRIO_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_plic_mt.sv
// tb/tb_plic_mt.sv - directed and randomized bench for plic_mt with a high-level interrupt model
module tb_plic_mt;

    localparam int NSRC = 16;
    localparam int NTGT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs;
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] src;
    logic [1:0]  irq;

    int total = 0;
    int bad   = 0;

    int        m_prio [1:NSRC];
    bit [15:0] m_en [NTGT];
    int        m_thr [NTGT];
    bit [15:0] m_srcv;
    bit [15:0] m_pend;
    bit [15:0] m_insv;

    plic_mt dut (
        .clk_i        (clk),
        .resetn_i     (rst_n),
        .chipselect_i (cs),
        .write_i      (wr),
        .read_i       (rd),
        .address_i    (addr),
        .writedata_i  (wdata),
        .readdata_o   (rdata),
        .irq_src_i    (src),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; addr = 8'h00; wdata = 32'h0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; addr = 8'h00;
        d = rdata;
    endtask

    // Highest priority among enabled pending sources, then the lowest ID holding it.
    function automatic int m_best(input int t);
        int top = 0;
        for (int id = 1; id <= NSRC; id++)
            if (m_pend[id-1] && m_en[t][id-1] && m_prio[id] > top) top = m_prio[id];
        if (top == 0) return 0;
        for (int id = 1; id <= NSRC; id++)
            if (m_pend[id-1] && m_en[t][id-1] && m_prio[id] == top) return id;
        return 0;
    endfunction

    function automatic bit m_irq(input int t);
        int b = m_best(t);
        return (b != 0) && (m_prio[b] > m_thr[t]);
    endfunction

    initial begin
        logic [31:0] d;
        int exp_ids [3];

        rst_n = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0;
        addr = 8'h00; wdata = 32'h0; src = 16'h0;
        tick(2);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        tick(1);
        bus_rd(8'h20, d); check("reset_pend", d, 32'h0);
        bus_rd(8'h01, d); check("reset_prio1", d, 32'h0);
        bus_rd(8'h40, d); check("reset_en0", d, 32'h0);

        // level source ID3: four-cycle latency, claim, complete after drop
        bus_wr(8'h03, 5); bus_wr(8'h40, 32'h4); bus_wr(8'h41, 2);
        bus_rd(8'h03, d); check("prio3_rb", d, 5);
        @(negedge clk); src[2] = 1'b1;
        tick(3); check("lat_3clk", 32'(irq[0]), 0);
        tick(1); check("lat_4clk", 32'(irq[0]), 1);
        bus_rd(8'h20, d); check("pend_id3", d, 32'h4);
        bus_rd(8'h60, d); check("claim_id3", d, 3);
        tick(1); check("irq_after_claim", 32'(irq[0]), 0);
        src[2] = 1'b0; tick(4);
        bus_wr(8'h60, 3); tick(4);
        bus_rd(8'h20, d); check("pend_after_cmpl", d, 32'h0);

        // arbitration: priority order, ties to the lowest ID
        bus_wr(8'h02, 4); bus_wr(8'h05, 4); bus_wr(8'h07, 6);
        bus_wr(8'h40, 32'h52);
        src = src | 16'h0052; tick(6);
        exp_ids[0] = 7; exp_ids[1] = 2; exp_ids[2] = 5;
        for (int i = 0; i < 3; i++) begin
            bus_rd(8'h60, d); check("arb_claim", d, 32'(exp_ids[i]));
            src[exp_ids[i]-1] = 1'b0; tick(4);
            bus_wr(8'h60, 32'(exp_ids[i])); tick(3);
        end
        bus_rd(8'h60, d); check("arb_claim_empty", d, 0);

        // threshold and two targets
        bus_wr(8'h04, 3); bus_wr(8'h41, 3); bus_wr(8'h43, 1);
        bus_wr(8'h40, 32'h8); bus_wr(8'h42, 32'h8);
        src[3] = 1'b1; tick(6);
        check("thr_irq", 32'(irq), 32'h2);
        bus_rd(8'h61, d); check("t1_claim", d, 4);
        tick(1);
        bus_rd(8'h60, d); check("t0_claim_after", d, 0);
        check("thr_irq_clear", 32'(irq), 0);
        src[3] = 1'b0; tick(4);
        bus_wr(8'h61, 4); tick(3);

        // complete rejected when the target does not enable the ID
        bus_wr(8'h06, 2); bus_wr(8'h41, 0); bus_wr(8'h40, 32'h20);
        src[5] = 1'b1; tick(6);
        bus_rd(8'h60, d); check("claim_id6", d, 6);
        bus_wr(8'h61, 6); tick(5);
        bus_rd(8'h20, d); check("reject_pend", d, 32'h0);
        bus_wr(8'h60, 6); tick(3);
        bus_rd(8'h20, d); check("repend_id6", d, 32'h20);
        src[5] = 1'b0;
        bus_rd(8'h60, d); check("claim_id6_again", d, 6);
        tick(4); bus_wr(8'h60, 6); tick(3);

`ifdef PLIC_EDGE_SEL_EN
        bus_wr(8'h01, 7); bus_wr(8'h40, 32'h1); bus_wr(8'h21, 32'h1);
        bus_rd(8'h21, d); check("esel_rb", d, 32'h1);
        src[0] = 1'b1; tick(3); src[0] = 1'b0; tick(3);
        bus_rd(8'h60, d); check("edge_claim1", d, 1);
        for (int i = 0; i < 3; i++) begin
            src[0] = 1'b1; tick(3); src[0] = 1'b0; tick(3);
        end
        bus_rd(8'h20, d); check("edge_busy_pend", d, 32'h0);
        bus_wr(8'h60, 1); tick(4);
        bus_rd(8'h20, d); check("edge_latched", d, 32'h1);
        bus_rd(8'h60, d); check("edge_claim2", d, 1);
        tick(1); bus_wr(8'h60, 1); tick(6);
        bus_rd(8'h60, d); check("edge_claim3", d, 0);
`else
        bus_wr(8'h21, 32'h1);
        bus_rd(8'h21, d); check("esel_absent", d, 32'h0);
`endif

        // asynchronous reset while an ID is in service and irq_o is high
        bus_wr(8'h08, 3); bus_wr(8'h09, 2); bus_wr(8'h40, 32'h180); bus_wr(8'h41, 0);
        src[7] = 1'b1; src[8] = 1'b1; tick(6);
        bus_rd(8'h60, d); check("rst_claim8", d, 8);
        tick(2); check("rst_irq_pre", 32'(irq[0]), 1);
        bus_rd(8'h08, d); check("rst_prio8_pre", d, 3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_irq", 32'(irq), 0);
        check("rst_async_rdata", rdata, 0);
        src = 16'h0;
        tick(2); rst_n = 1'b1; tick(1);
        bus_rd(8'h08, d); check("rst_prio8", d, 0);
        bus_rd(8'h40, d); check("rst_en0", d, 0);
        bus_rd(8'h41, d); check("rst_thr0", d, 0);
        bus_rd(8'h20, d); check("rst_pend", d, 0);
        bus_rd(8'h60, d); check("rst_claim", d, 0);

        // randomized level traffic against the model
        m_srcv = '0; m_pend = '0; m_insv = '0;
        for (int id = 1; id <= NSRC; id++) begin
            m_prio[id] = int'($urandom_range(0, 7));
            bus_wr(8'(id), 32'(m_prio[id]));
        end
        for (int t = 0; t < NTGT; t++) begin
            m_en[t]  = 16'($urandom_range(0, 16'hFFFF));
            m_thr[t] = int'($urandom_range(0, 3));
            bus_wr(8'(64 + 2 * t), 32'(m_en[t]));
            bus_wr(8'(65 + 2 * t), 32'(m_thr[t]));
        end
        tick(2);
        for (int it = 0; it < 60; it++) begin
            int act = int'($urandom_range(0, 2));
            int t   = int'($urandom_range(0, NTGT - 1));
            int id  = int'($urandom_range(1, NSRC));
            if (act == 0) begin
                m_srcv[id-1] = ~m_srcv[id-1];
                src[id-1]    = m_srcv[id-1];
            end else if (act == 1) begin
                int e = m_best(t);
                bus_rd(8'(96 + t), d); check("rand_claim", d, 32'(e));
                if (e != 0) begin
                    m_pend[e-1] = 1'b0;
                    m_insv[e-1] = 1'b1;
                end
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    for (int k = 1; k <= NSRC; k++) if (m_insv[k-1]) id = k;
                end
                bus_wr(8'(96 + t), 32'(id));
                if (m_insv[id-1] && m_en[t][id-1]) m_insv[id-1] = 1'b0;
            end
            tick(6);
            m_pend = m_pend | (m_srcv & ~m_insv);
            check("rand_irq", 32'(irq), 32'({m_irq(1), m_irq(0)}));
            bus_rd(8'h20, d); check("rand_pend", d, 32'(m_pend));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
